// File: rtl/dmb_rdout_pkg.sv
// Shared definitions for the DMB readout scheduler: state encoding,
// TMB select code and the default CFEB count.
package dmb_rdout_pkg;

    localparam int NCFEB_DEF = 7;

    // SEL value that addresses the ALCT/TMB slot rather than a CFEB FIFO
    localparam logic [3:0] SEL_TMB = 4'hF;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD      = 4'd1,
        PICK      = 4'd2,
        WAIT_DATA = 4'd3,
        ISSUE     = 4'd4,
        RUN       = 4'd5,
        TMO       = 4'd6,
        CLR       = 4'd7,
        EOE_ST    = 4'd8
    } sched_state_e;

    // A slot counts as active from the moment it is selected until it either
    // completes or times out.
    function automatic logic slot_active(input sched_state_e s);
        return (s == WAIT_DATA) || (s == ISSUE) || (s == RUN);
    endfunction

endpackage

// File: rtl/rdout_prio_enc.sv
// Priority encoder over the pending-slot vector. The TMB bit (MSB) wins,
// otherwise the lowest-numbered pending CFEB is chosen.
module rdout_prio_enc
    import dmb_rdout_pkg::*;
#(
    parameter int NCFEB = NCFEB_DEF
) (
    input  logic [NCFEB:0] pend,
    output logic           valid,
    output logic [3:0]     idx
);

    // Scan high to low so the lowest CFEB index is the last one written
    always_comb begin
        valid = |pend;
        idx   = 4'd0;
        for (int i = NCFEB - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = 4'(i);
            end
        end
        if (pend[NCFEB]) begin
            idx = SEL_TMB;
        end
    end

endmodule

// File: rtl/cfeb_rdout_sched.sv
// Per-event readout scheduler. Captures which sources carry data at the
// event header, then hands them one at a time (TMB first, then CFEBs in
// ascending order) to the L1A checker, with per-slot wait/run timeouts.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for HEADER_END
// LOAD      | capture pending sources, clear timeout mask
// PICK      | select next pending slot or finish the event
// WAIT_DATA | wait for the selected FIFO to go non-empty
// ISSUE     | GO pulse to the checker
// RUN       | wait for SLOT_DONE from the checker
// TMO       | slot timed out, flag it
// CLR       | retire the current slot from the pending set
// EOE_ST    | end-of-event pulse
module cfeb_rdout_sched
    import dmb_rdout_pkg::*;
#(
    parameter int NCFEB    = NCFEB_DEF,
    parameter int TMO_W    = 10,
    parameter int WAIT_TMO = 255,
    parameter int RUN_TMO  = 1000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             HEADER_END,
    input  logic             TMB_REQ,
    input  logic [NCFEB-1:0] CFEB_MASK,
    input  logic [NCFEB-1:0] FIFO_MT,
    input  logic             SLOT_DONE,
    output logic             GO,
    output logic [3:0]       SEL,
    output logic             ALCT_TMB_ACT,
    output logic             CFEB_ACT,
    output logic             EOE,
    output logic             TMO_ERR,
    output logic [NCFEB:0]   TMO_MASK,
    output logic             BUSY
);

    localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(WAIT_TMO - 1);
    localparam logic [TMO_W-1:0] RUN_LAST  = TMO_W'(RUN_TMO - 1);
    localparam logic [TMO_W-1:0] TMR_ONE   = TMO_W'(1);

    sched_state_e     state_q, state_d;
    logic [NCFEB:0]   pend_q, pend_d;
    logic [3:0]       sel_q, sel_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic [NCFEB:0]   tmo_mask_q, tmo_mask_d;

    logic go_q, go_d;
    logic eoe_q, eoe_d;
    logic tmo_err_q, tmo_err_d;
    logic tmb_act_q, tmb_act_d;
    logic cfeb_act_q, cfeb_act_d;
    logic busy_q, busy_d;

    logic           enc_valid;
    logic [3:0]     enc_idx;
    logic [NCFEB:0] slot_oh;
    logic [15:0]    mt_ext;
    logic           slot_ready;

    rdout_prio_enc #(
        .NCFEB (NCFEB)
    ) u_prio_enc (
        .pend  (pend_q),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Decode the current selection into a pending-vector one-hot and a
    // readiness flag. Unused FIFO positions read as empty; the TMB slot
    // has no FIFO of its own and is always ready.
    always_comb begin
        mt_ext                = '1;
        mt_ext[NCFEB-1:0]     = FIFO_MT;
        slot_ready            = (sel_q == SEL_TMB) || !mt_ext[sel_q];
        slot_oh               = '0;
        for (int i = 0; i < NCFEB; i++) begin
            slot_oh[i] = (sel_q == 4'(i));
        end
        slot_oh[NCFEB]        = (sel_q == SEL_TMB);
    end

    // Next-state and data-path update; outputs are decoded from the next
    // state so that they line up with the registered state.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        sel_d      = sel_q;
        timer_d    = timer_q;
        tmo_mask_d = tmo_mask_q;

        case (state_q)
            IDLE: begin
                if (HEADER_END) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pend_d     = {TMB_REQ, CFEB_MASK};
                tmo_mask_d = '0;
                state_d    = PICK;
            end
            PICK: begin
                if (!enc_valid) begin
                    state_d = EOE_ST;
                end else begin
                    sel_d   = enc_idx;
                    timer_d = '0;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // readiness is checked first so data arriving on the last
                // wait cycle still gets issued
                if (slot_ready) begin
                    state_d = ISSUE;
                end else if (timer_q == WAIT_LAST) begin
                    state_d = TMO;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = RUN;
            end
            RUN: begin
                // completion beats a coincident timeout
                if (SLOT_DONE) begin
                    state_d = CLR;
                end else if (timer_q == RUN_LAST) begin
                    state_d = TMO;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            TMO: begin
                tmo_mask_d = tmo_mask_q | slot_oh;
                state_d    = CLR;
            end
            CLR: begin
                pend_d  = pend_q & ~slot_oh;
                state_d = PICK;
            end
            EOE_ST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        go_d       = (state_d == ISSUE);
        eoe_d      = (state_d == EOE_ST);
        tmo_err_d  = (state_d == TMO);
        busy_d     = (state_d != IDLE);
        tmb_act_d  = slot_active(state_d) && (sel_d == SEL_TMB);
        cfeb_act_d = slot_active(state_d) && (sel_d != SEL_TMB);
    end

    // State, data and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            sel_q      <= 4'd0;
            timer_q    <= '0;
            tmo_mask_q <= '0;
            go_q       <= 1'b0;
            eoe_q      <= 1'b0;
            tmo_err_q  <= 1'b0;
            tmb_act_q  <= 1'b0;
            cfeb_act_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            sel_q      <= sel_d;
            timer_q    <= timer_d;
            tmo_mask_q <= tmo_mask_d;
            go_q       <= go_d;
            eoe_q      <= eoe_d;
            tmo_err_q  <= tmo_err_d;
            tmb_act_q  <= tmb_act_d;
            cfeb_act_q <= cfeb_act_d;
            busy_q     <= busy_d;
        end
    end

    assign GO           = go_q;
    assign SEL          = sel_q;
    assign ALCT_TMB_ACT = tmb_act_q;
    assign CFEB_ACT     = cfeb_act_q;
    assign EOE          = eoe_q;
    assign TMO_ERR      = tmo_err_q;
    assign TMO_MASK     = tmo_mask_q;
    assign BUSY         = busy_q;

endmodule

// File: tb/tb_cfeb_rdout_sched.sv
// Directed bench for cfeb_rdout_sched with hand-computed cycle counts.
module tb_cfeb_rdout_sched;

    localparam int NCFEB    = 7;
    localparam int TMO_W    = 10;
    localparam int WAIT_TMO = 255;
    localparam int RUN_TMO  = 1000;

    logic             CLK = 1'b0;
    logic             RST;
    logic             HEADER_END;
    logic             TMB_REQ;
    logic [NCFEB-1:0] CFEB_MASK;
    logic [NCFEB-1:0] FIFO_MT;
    logic             SLOT_DONE;
    logic             GO;
    logic [3:0]       SEL;
    logic             ALCT_TMB_ACT;
    logic             CFEB_ACT;
    logic             EOE;
    logic             TMO_ERR;
    logic [NCFEB:0]   TMO_MASK;
    logic             BUSY;

    int errors = 0;
    int checks = 0;
    int go_cnt = 0;
    int eoe_cnt = 0;
    int tmo_cnt = 0;

    cfeb_rdout_sched #(
        .NCFEB    (NCFEB),
        .TMO_W    (TMO_W),
        .WAIT_TMO (WAIT_TMO),
        .RUN_TMO  (RUN_TMO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .HEADER_END   (HEADER_END),
        .TMB_REQ      (TMB_REQ),
        .CFEB_MASK    (CFEB_MASK),
        .FIFO_MT      (FIFO_MT),
        .SLOT_DONE    (SLOT_DONE),
        .GO           (GO),
        .SEL          (SEL),
        .ALCT_TMB_ACT (ALCT_TMB_ACT),
        .CFEB_ACT     (CFEB_ACT),
        .EOE          (EOE),
        .TMO_ERR      (TMO_ERR),
        .TMO_MASK     (TMO_MASK),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    // pulse counters, sampled mid-cycle
    always @(negedge CLK) begin
        if (GO === 1'b1)      go_cnt++;
        if (EOE === 1'b1)     eoe_cnt++;
        if (TMO_ERR === 1'b1) tmo_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return GO;
            1:       return EOE;
            default: return TMO_ERR;
        endcase
    endfunction

    // ticks until the chosen pulse is seen; n = -1 when the bound expires
    task automatic wait_for(input int which, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (sig(which) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic done_after(input int k);
        repeat (k) tick();
        SLOT_DONE = 1'b1;
        tick();
        SLOT_DONE = 1'b0;
    endtask

    task automatic start_event();
        HEADER_END = 1'b1;
        tick();
        HEADER_END = 1'b0;
    endtask

    initial begin
        int n;
        int g0, e0, t0;

        RST        = 1'b1;
        HEADER_END = 1'b0;
        TMB_REQ    = 1'b0;
        CFEB_MASK  = '0;
        FIFO_MT    = '0;
        SLOT_DONE  = 1'b0;
        tick();
        tick();
        chk("rst_go",   32'(GO), 0);
        chk("rst_sel",  32'(SEL), 0);
        chk("rst_eoe",  32'(EOE), 0);
        chk("rst_tmo",  32'(TMO_ERR), 0);
        chk("rst_mask", 32'(TMO_MASK), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_act",  32'({ALCT_TMB_ACT, CFEB_ACT}), 0);
        RST = 1'b0;
        tick();

        // 1: TMB + CFEB0 + CFEB2, all ready, mask changes after LOAD ignored
        g0 = go_cnt; e0 = eoe_cnt;
        TMB_REQ = 1'b1; CFEB_MASK = 7'b0000101;
        start_event();
        chk("t1_busy", 32'(BUSY), 1);
        tick();
        TMB_REQ = 1'b0; CFEB_MASK = 7'h7F;
        wait_for(0, 20, n);
        chk("t1_go0_lat", n, 2);
        chk("t1_sel0", 32'(SEL), 15);
        chk("t1_tmb_act", 32'({ALCT_TMB_ACT, CFEB_ACT}), 2);
        done_after(5);
        wait_for(0, 20, n);
        chk("t1_go1_lat", n, 3);
        chk("t1_sel1", 32'(SEL), 0);
        chk("t1_cfeb_act", 32'({ALCT_TMB_ACT, CFEB_ACT}), 1);
        done_after(5);
        wait_for(0, 20, n);
        chk("t1_go2_lat", n, 3);
        chk("t1_sel2", 32'(SEL), 2);
        done_after(5);
        wait_for(1, 20, n);
        chk("t1_eoe_lat", n, 2);
        chk("t1_mask", 32'(TMO_MASK), 0);
        tick();
        chk("t1_idle", 32'(BUSY), 0);
        repeat (3) tick();
        chk("t1_go_cnt", go_cnt - g0, 3);
        chk("t1_eoe_cnt", eoe_cnt - e0, 1);
        CFEB_MASK = '0;

        // 2: CFEB3 FIFO stays empty -> wait timeout
        g0 = go_cnt; t0 = tmo_cnt;
        CFEB_MASK = 7'b0001000; FIFO_MT = 7'b0001000;
        start_event();
        wait_for(2, 400, n);
        chk("t2_tmo_lat", n, WAIT_TMO + 2);
        wait_for(1, 20, n);
        chk("t2_eoe_lat", n, 3);
        chk("t2_mask", 32'(TMO_MASK), 8'h08);
        tick();
        chk("t2_go_cnt", go_cnt - g0, 0);
        chk("t2_tmo_cnt", tmo_cnt - t0, 1);

        // 2b: FIFO goes non-empty on the last wait cycle -> ready wins
        t0 = tmo_cnt;
        start_event();
        repeat (WAIT_TMO + 1) tick();
        FIFO_MT = '0;
        tick();
        chk("t2b_go", 32'(GO), 1);
        chk("t2b_tmo", 32'(TMO_ERR), 0);
        done_after(2);
        wait_for(1, 20, n);
        chk("t2b_eoe_lat", n, 2);
        chk("t2b_mask", 32'(TMO_MASK), 0);
        tick();
        chk("t2b_tmo_cnt", tmo_cnt - t0, 0);

        // 3: CFEB1, SLOT_DONE never arrives -> run timeout
        CFEB_MASK = 7'b0000010;
        start_event();
        wait_for(0, 20, n);
        chk("t3_go_lat", n, 3);
        chk("t3_sel", 32'(SEL), 1);
        wait_for(2, 1100, n);
        chk("t3_tmo_lat", n, RUN_TMO + 1);
        wait_for(1, 20, n);
        chk("t3_eoe_lat", n, 3);
        chk("t3_mask", 32'(TMO_MASK), 8'h02);
        tick();

        // 3b: SLOT_DONE on the timeout cycle -> done wins
        t0 = tmo_cnt;
        start_event();
        wait_for(0, 20, n);
        chk("t3b_go_lat", n, 3);
        repeat (RUN_TMO) tick();
        SLOT_DONE = 1'b1;
        tick();
        SLOT_DONE = 1'b0;
        chk("t3b_tmo", 32'(TMO_ERR), 0);
        chk("t3b_act", 32'(CFEB_ACT), 0);
        wait_for(1, 20, n);
        chk("t3b_eoe_lat", n, 2);
        chk("t3b_mask", 32'(TMO_MASK), 0);
        tick();
        chk("t3b_tmo_cnt", tmo_cnt - t0, 0);

        // 4: empty event, second HEADER_END during PICK ignored
        g0 = go_cnt; e0 = eoe_cnt;
        CFEB_MASK = '0; TMB_REQ = 1'b0;
        start_event();
        chk("t4_busy", 32'(BUSY), 1);
        tick();
        HEADER_END = 1'b1;
        tick();
        HEADER_END = 1'b0;
        chk("t4_eoe_c3", 32'(EOE), 1);
        tick();
        chk("t4_eoe_c4", 32'(EOE), 0);
        chk("t4_idle", 32'(BUSY), 0);
        repeat (4) tick();
        chk("t4_eoe_cnt", eoe_cnt - e0, 1);
        chk("t4_go_cnt", go_cnt - g0, 0);
        chk("t4_busy_end", 32'(BUSY), 0);

        // 5: CFEB1 times out, then reset during RUN of CFEB4
        CFEB_MASK = 7'b0010010; FIFO_MT = 7'b0000010;
        start_event();
        wait_for(2, 400, n);
        chk("t5_tmo_lat", n, WAIT_TMO + 2);
        wait_for(0, 20, n);
        chk("t5_go_lat", n, 4);
        chk("t5_sel", 32'(SEL), 4);
        chk("t5_mask_pre", 32'(TMO_MASK), 8'h02);
        tick();
        tick();
        e0 = eoe_cnt; t0 = tmo_cnt;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t5_rst_go",   32'(GO), 0);
        chk("t5_rst_sel",  32'(SEL), 0);
        chk("t5_rst_act",  32'({ALCT_TMB_ACT, CFEB_ACT}), 0);
        chk("t5_rst_eoe",  32'(EOE), 0);
        chk("t5_rst_tmo",  32'(TMO_ERR), 0);
        chk("t5_rst_mask", 32'(TMO_MASK), 0);
        chk("t5_rst_busy", 32'(BUSY), 0);
        repeat (3) tick();
        chk("t5_idle", 32'(BUSY), 0);
        chk("t5_no_eoe", eoe_cnt - e0, 0);
        chk("t5_no_tmo", tmo_cnt - t0, 0);

        CFEB_MASK = 7'b0010000; FIFO_MT = '0;
        start_event();
        wait_for(0, 20, n);
        chk("t5b_go_lat", n, 3);
        chk("t5b_sel", 32'(SEL), 4);
        chk("t5b_mask", 32'(TMO_MASK), 0);
        done_after(5);
        wait_for(1, 20, n);
        chk("t5b_eoe_lat", n, 2);
        chk("t5b_mask_end", 32'(TMO_MASK), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
